// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit data-memory path.
// Sizes, FSM states and the alignment rule live here so both files agree.
package lsu_pkg;

    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 1024;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MRG  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } state_e;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return (size == SZ_BAD)
            || (size == SZ_HALF && off[0])
            || (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: load extraction with sign/zero extension and
// store merge of a sub-word into the word read back from memory.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] st_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = rdata[{off, 3'b000} +: 8];
        half_v  = off[1] ? rdata[31:16] : rdata[15:0];
        ld_data = rdata;
        st_data = rdata;
        unique case (size)
            SZ_BYTE: begin
                ld_data = {{24{~uns & byte_v[7]}}, byte_v};
                st_data[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ld_data = {{16{~uns & half_v[15]}}, half_v};
                if (off[1]) begin
                    st_data[31:16] = wdata[15:0];
                end else begin
                    st_data[15:0] = wdata[15:0];
                end
            end
            SZ_WORD: begin
                ld_data = rdata;
                st_data = wdata;
            end
            default: begin
                ld_data = rdata;
                st_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller in front of a synchronous-read word DMEM.
// Sub-word stores are done as read-modify-write of the containing word.
module lsu_dmem_ctrl #(
    parameter  int DATA_W    = 32,
    parameter  int MEM_DEPTH = 1024,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_misaligned,
    output logic              wren,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    import lsu_pkg::*;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                mis_q, mis_d;
    logic [DATA_W-1:0]   mdata_q, mdata_d;

    logic                accept;
    logic                mis_req;
    logic [DATA_W-1:0]   ld_data;
    logic [DATA_W-1:0]   st_data;
    logic                addr_unused;

    // Upper address bits wrap the 4 KiB window and are deliberately dropped.
    assign addr_unused = ^req_addr[31:ADDR_W+2];
    assign accept      = req_valid && (state_q == IDLE);
    assign mis_req     = is_misaligned(req_size, req_addr[1:0]);

    lsu_lane_align u_align (
        .size    (size_q),
        .uns     (uns_q),
        .off     (addr_q[1:0]),
        .rdata   (data_out),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (mis_req) begin
                        state_d = RSP;
                    end else if (req_we && req_size == SZ_WORD) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = MRG;
            MRG:     state_d = we_q ? WR : RSP;
            WR:      state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            mdata_q <= '0;
        end else begin
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            mdata_q <= mdata_d;
        end
    end

    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        mdata_d = mdata_q;
        if (accept) begin
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            addr_d  = req_addr[ADDR_W+1:0];
            wdata_d = req_wdata;
            mis_d   = mis_req;
            mdata_d = '0;
        end else if (state_q == MRG) begin
            mdata_d = we_q ? st_data : ld_data;
        end
    end

    always_comb begin
        req_ready      = (state_q == IDLE);
        rsp_valid      = (state_q == RSP);
        rsp_misaligned = (state_q == RSP) && mis_q;
        rsp_rdata      = '0;
        if (state_q == RSP && !we_q && !mis_q) begin
            rsp_rdata = mdata_q;
        end
        wren    = (state_q == WR);
        address = addr_q[ADDR_W+1:2];
        data_in = '0;
        if (state_q == WR) begin
            data_in = (size_q == SZ_WORD) ? wdata_q : mdata_q;
        end
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl with a synchronous-read DMEM model and a
// scoreboard queue of expected responses.
module tb_lsu_dmem_ctrl;

    logic        clock;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        wren;
    logic [9:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;

    logic [31:0] mem [1024];
    int          wren_cnt = 0;
    logic [9:0]  wr_addr  = '0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          nwr;
    } exp_t;

    exp_t sb[$];

    lsu_dmem_ctrl dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .wren           (wren),
        .address        (address),
        .data_in        (data_in),
        .data_out       (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (wren) begin
            mem[address] <= data_in;
            wren_cnt     <= wren_cnt + 1;
            wr_addr      <= address;
        end
        data_out <= mem[address];
    end

    task automatic run_req(
        input logic        we,
        input logic [1:0]  sz,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input logic [31:0] er,
        input logic        em,
        input int          lat,
        input int          nwr,
        input string       name
    );
        exp_t e;
        exp_t got;
        int   cyc;
        int   w0;
        e = '{rdata: er, mis: em, lat: lat, nwr: nwr};
        sb.push_back(e);
        cyc = 0;
        @(negedge clock);
        while (!req_ready && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready: got %b want 1", name, req_ready);
        end
        w0           = wren_cnt;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        got = sb.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || cyc != got.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d (valid %b) want %0d",
                     name, cyc, rsp_valid, got.lat);
        end
        checks++;
        if (rsp_rdata !== got.rdata) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h",
                     name, rsp_rdata, got.rdata);
        end
        checks++;
        if (rsp_misaligned !== got.mis) begin
            failures++;
            $display("FAIL %s misaligned: got %b want %b",
                     name, rsp_misaligned, got.mis);
        end
        checks++;
        if (wren_cnt - w0 != got.nwr) begin
            failures++;
            $display("FAIL %s wren cycles: got %0d want %0d",
                     name, wren_cnt - w0, got.nwr);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        #3;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0
            || rsp_misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset handshake: got rdy %b vld %b mis %b want 1 0 0",
                     req_ready, rsp_valid, rsp_misaligned);
        end
        checks++;
        if (rsp_rdata !== 32'h0 || data_in !== 32'h0) begin
            failures++;
            $display("FAIL reset data: got rdata %h din %h want 0 0",
                     rsp_rdata, data_in);
        end
        checks++;
        if (wren !== 1'b0 || address !== 10'd0) begin
            failures++;
            $display("FAIL reset dmem: got wren %b addr %0d want 0 0",
                     wren, address);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        run_req(1'b1, 2'b10, 1'b0, 32'h0D4, 32'hDEADBEEF,
                32'h0, 1'b0, 2, 1, "sw_d4");
        checks++;
        if (wr_addr !== 10'd53) begin
            failures++;
            $display("FAIL sw_d4 address: got %0d want 53", wr_addr);
        end
        checks++;
        if (mem[53] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_d4 mem: got %h want deadbeef", mem[53]);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h0D4, 32'h0,
                32'hDEADBEEF, 1'b0, 3, 0, "lw_d4");
        run_req(1'b0, 2'b10, 1'b0, 32'hFFFFF0D4, 32'h0,
                32'hDEADBEEF, 1'b0, 3, 0, "lw_wrap");
    endtask

    task automatic test_byte();
        run_req(1'b1, 2'b10, 1'b0, 32'h010, 32'h11223344,
                32'h0, 1'b0, 2, 1, "sw_10");
        run_req(1'b1, 2'b00, 1'b0, 32'h011, 32'h12345680,
                32'h0, 1'b0, 4, 1, "sb_11");
        checks++;
        if (mem[4] !== 32'h11228044) begin
            failures++;
            $display("FAIL sb_11 mem: got %h want 11228044", mem[4]);
        end
        run_req(1'b0, 2'b00, 1'b0, 32'h011, 32'h0,
                32'hFFFFFF80, 1'b0, 3, 0, "lb_11");
        run_req(1'b0, 2'b00, 1'b1, 32'h011, 32'h0,
                32'h00000080, 1'b0, 3, 0, "lbu_11");
        run_req(1'b0, 2'b00, 1'b0, 32'h013, 32'h0,
                32'h00000011, 1'b0, 3, 0, "lb_13");
        run_req(1'b0, 2'b01, 1'b0, 32'h010, 32'h0,
                32'hFFFF8044, 1'b0, 3, 0, "lh_10");
    endtask

    task automatic test_half();
        run_req(1'b1, 2'b10, 1'b0, 32'h004, 32'h0,
                32'h0, 1'b0, 2, 1, "sw_04");
        run_req(1'b1, 2'b01, 1'b0, 32'h006, 32'hAAAABEEF,
                32'h0, 1'b0, 4, 1, "sh_06");
        checks++;
        if (mem[1] !== 32'hBEEF0000) begin
            failures++;
            $display("FAIL sh_06 mem: got %h want beef0000", mem[1]);
        end
        run_req(1'b0, 2'b01, 1'b0, 32'h006, 32'h0,
                32'hFFFFBEEF, 1'b0, 3, 0, "lh_06");
        run_req(1'b0, 2'b01, 1'b1, 32'h006, 32'h0,
                32'h0000BEEF, 1'b0, 3, 0, "lhu_06");
    endtask

    task automatic test_misaligned();
        run_req(1'b0, 2'b10, 1'b0, 32'h002, 32'h0,
                32'h0, 1'b1, 1, 0, "lw_02");
        run_req(1'b1, 2'b01, 1'b0, 32'h001, 32'hFFFF,
                32'h0, 1'b1, 1, 0, "sh_01");
        run_req(1'b0, 2'b11, 1'b0, 32'h000, 32'h0,
                32'h0, 1'b1, 1, 0, "sz11");
        checks++;
        if (mem[0] !== 32'h0) begin
            failures++;
            $display("FAIL sh_01 mem: got %h want 0", mem[0]);
        end
    endtask

    task automatic test_reset_abort();
        int w0;
        @(negedge clock);
        w0           = wren_cnt;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h011;
        req_wdata    = 32'h000000AA;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wren !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort state: got wren %b rdy %b want 0 1",
                     wren, req_ready);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (wren_cnt != w0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort wren: got %0d writes vld %b want 0 0",
                     wren_cnt - w0, rsp_valid);
        end
        checks++;
        if (mem[4] !== 32'h11228044) begin
            failures++;
            $display("FAIL abort mem: got %h want 11228044", mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clock);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h0D4;
        req_wdata    = 32'h0;
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b busy%0d ready: got %b want 0", k, req_ready);
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b idle: got rdy %b vld %b want 1 0",
                     req_ready, rsp_valid);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b second accept: got rdy %b want 0", req_ready);
        end
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || cyc != 3 || rsp_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL b2b second rsp: got lat %0d data %h want 3 deadbeef",
                     cyc, rsp_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
